// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone-classic RAM responder with wait states and range errors.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   adr_i, dat_i          word address and write data
//   wen_i, sel_i          write enable and byte-lane enables
//   stb_i, cyc_i          strobe and bus-cycle qualifier
//   dat_o                 read data, nonzero only alongside ack_o
//   ack_o, err_o, rty_o   completion pulses; rty_o is always 0
// Optional feature: define WB_RESPONDER_WRPROT_EN to make the lowest quarter
// of the RAM read-only (writes there complete with err_o).
module wb_ram_responder #(
    parameter logic [31:0] BASE      = 32'h0000_1000,
    parameter int          ADDR_BITS = 10,
    parameter int          WAIT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        wen_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_ctr;
    logic [31:0] r_adr, r_dat, r_rdata;
    logic        r_wen, r_ack, r_err;
    logic [3:0]  r_sel;
    logic [31:0] r_mem [0:2**ADDR_BITS-1];
    logic        w_req, w_commit, w_wen, w_bad, w_prot;
    logic [31:0] w_adr, w_dat, w_off;
    logic [3:0]  w_sel;
    logic [ADDR_BITS-1:0] w_idx;

    assign w_req = cyc_i & stb_i;
    // With WAIT==0 the commit happens on the sampling edge, so the live bus is used.
    assign w_adr = (r_state == S_IDLE) ? adr_i : r_adr;
    assign w_dat = (r_state == S_IDLE) ? dat_i : r_dat;
    assign w_wen = (r_state == S_IDLE) ? wen_i : r_wen;
    assign w_sel = (r_state == S_IDLE) ? sel_i : r_sel;
    assign w_off = w_adr - BASE;
    assign w_idx = w_off[ADDR_BITS-1:0];
`ifdef WB_RESPONDER_WRPROT_EN
    assign w_prot = w_wen && ((w_off >> (ADDR_BITS - 2)) == '0);
`else
    assign w_prot = 1'b0;
`endif
    assign w_bad    = ((w_off >> ADDR_BITS) != '0) || w_prot;
    assign w_commit = (w_next == S_RESP);

    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_req ? ((WAIT == 0) ? S_RESP : S_WAIT) : S_IDLE) :
                 (r_state == S_WAIT) ? (!w_req ? S_IDLE : (r_ctr == 4'd1) ? S_RESP : S_WAIT) :
                 S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ctr   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_wen   <= 1'b0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_adr <= adr_i;
                r_dat <= dat_i;
                r_wen <= wen_i;
                r_sel <= sel_i;
                r_ctr <= 4'(WAIT);
            end else if (r_state == S_WAIT) begin
                r_ctr <= r_ctr - 4'd1;
            end
            r_ack   <= w_commit && !w_bad;
            r_err   <= w_commit && w_bad;
            r_rdata <= (w_commit && !w_bad && !w_wen) ? r_mem[w_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_wen && !w_bad)
            for (int b = 0; b < 4; b++)
                if (w_sel[b]) r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
    end

    assign dat_o = r_rdata;
    assign ack_o = r_ack;
    assign err_o = r_err;
    assign rty_o = 1'b0;
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed bench for wb_ram_responder at WAIT=1, 3 and 0.
module tb_wb_ram_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef WB_RESPONDER_WRPROT_EN
    localparam logic [31:0] OFS = 32'd256;
`else
    localparam logic [31:0] OFS = 32'd0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic        wen = 1'b0, stb = 1'b0;
    logic [3:0]  sel = '0;
    logic [2:0]  cyc = '0, ack, err, rty;
    logic [31:0] dout [3];
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    wb_ram_responder #(.BASE(BASE), .ADDR_BITS(10), .WAIT(1)) u0 (
        .clk(clk), .reset(reset), .adr_i(adr), .dat_i(dat), .dat_o(dout[0]), .wen_i(wen),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc[0]), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]));
    wb_ram_responder #(.BASE(BASE), .ADDR_BITS(10), .WAIT(3)) u1 (
        .clk(clk), .reset(reset), .adr_i(adr), .dat_i(dat), .dat_o(dout[1]), .wen_i(wen),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc[1]), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]));
    wb_ram_responder #(.BASE(BASE), .ADDR_BITS(10), .WAIT(0)) u2 (
        .clk(clk), .reset(reset), .adr_i(adr), .dat_i(dat), .dat_o(dout[2]), .wen_i(wen),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc[2]), .ack_o(ack[2]), .err_o(err[2]), .rty_o(rty[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int u, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string t,
                        output logic ak, output logic er, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        adr = a; dat = d; wen = we; sel = s; stb = 1'b1; cyc[u] = 1'b1;
        ak = 1'b0; er = 1'b0; rd = '0; lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ack[u] | err[u]) begin
                ak = ack[u]; er = err[u]; rd = dout[u]; lat = n;
            end
        end
        stb = 1'b0; cyc[u] = 1'b0;
        @(posedge clk); #1;
        chk({t, ".pulse"}, {ack[u], err[u]}, 2'b00);
        chk({t, ".dat0"}, dout[u], 32'h0);
    endtask

    task automatic do_wr(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic e, input int l, input string t);
        logic ak, er;
        logic [31:0] rd;
        int lat;
        xfer(u, 1'b1, a, d, s, t, ak, er, rd, lat);
        chk({t, ".ack"}, ak, !e);
        chk({t, ".err"}, er, e);
        chk({t, ".lat"}, lat, l);
    endtask

    task automatic do_rd(input int u, input logic [31:0] a, input logic [31:0] x,
                         input logic e, input int l, input string t);
        logic ak, er;
        logic [31:0] rd;
        int lat;
        xfer(u, 1'b0, a, 32'h0, 4'hF, t, ak, er, rd, lat);
        chk({t, ".ack"}, ak, !e);
        chk({t, ".err"}, er, e);
        chk({t, ".lat"}, lat, l);
        chk({t, ".data"}, rd, x);
    endtask

    task automatic quiet(input int u, input string t);
        logic seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ack[u] | err[u];
        end
        chk(t, seen, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst.ack%0d", u), ack[u], 1'b0);
            chk($sformatf("rst.err%0d", u), err[u], 1'b0);
            chk($sformatf("rst.rty%0d", u), rty[u], 1'b0);
            chk($sformatf("rst.dat%0d", u), dout[u], 32'h0);
        end
        reset = 1'b0;

        do_wr(0, BASE + OFS + 3, 32'hDEADBEEF, 4'hF, 1'b0, 2, "t1w");
        do_rd(0, BASE + OFS + 3, 32'hDEADBEEF, 1'b0, 2, "t1r");

        do_wr(0, BASE + OFS + 3, 32'h0000AB00, 4'b0010, 1'b0, 2, "t2w");
        do_rd(0, BASE + OFS + 3, 32'hDEADABEF, 1'b0, 2, "t2r");

        do_wr(0, BASE + 1023, 32'h11111111, 4'hF, 1'b0, 2, "t3pre");
        do_rd(0, BASE - 1, 32'h0, 1'b1, 2, "t3rlo");
        do_rd(0, BASE + 1024, 32'h0, 1'b1, 2, "t3rhi");
        do_wr(0, BASE + 1024, 32'hFFFFFFFF, 4'hF, 1'b1, 2, "t3whi");
        do_wr(0, BASE - 1, 32'hFFFFFFFF, 4'hF, 1'b1, 2, "t3wlo");
        do_wr(0, BASE + 1023, 32'h0, 4'h0, 1'b0, 2, "t3sel0");
        do_rd(0, BASE + 1023, 32'h11111111, 1'b0, 2, "t3nb");

        // Reset arriving while the ack pulse is on the bus clears it without a clock.
        @(posedge clk); #1;
        adr = BASE + 1023; wen = 1'b0; sel = 4'hF; stb = 1'b1; cyc[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rresp.ack", ack[0], 1'b1);
        chk("rresp.dat", dout[0], 32'h11111111);
        reset = 1'b1; stb = 1'b0; cyc[0] = 1'b0;
        #1;
        chk("rresp.ack0", ack[0], 1'b0);
        chk("rresp.dat0", dout[0], 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_wr(1, BASE + OFS, 32'hCAFE0000, 4'hF, 1'b0, 4, "t4w");
        @(posedge clk); #1;
        adr = BASE + OFS; dat = 32'h1; wen = 1'b1; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; cyc[1] = 1'b0;
        quiet(1, "t4abort");
        do_rd(1, BASE + OFS, 32'hCAFE0000, 1'b0, 4, "t4r");

        @(posedge clk); #1;
        adr = BASE + OFS; dat = 32'h2; wen = 1'b1; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; stb = 1'b0; cyc[1] = 1'b0;
        #1;
        chk("t4rst.out", {ack[1], err[1]}, 2'b00);
        chk("t4rst.dat", dout[1], 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        quiet(1, "t4rst.idle");
        do_rd(1, BASE + OFS, 32'hCAFE0000, 1'b0, 4, "t4rst.r");

        for (int i = 0; i < 8; i++)
            do_wr(2, BASE + OFS + 64 + i, 32'hA5000000 | i, 4'hF, 1'b0, 1, $sformatf("t5w%0d", i));
        for (int i = 0; i < 8; i++)
            do_rd(2, BASE + OFS + 64 + i, 32'hA5000000 | i, 1'b0, 1, $sformatf("t5r%0d", i));

`ifdef WB_RESPONDER_WRPROT_EN
        do_wr(0, BASE + 1, 32'h5, 4'hF, 1'b1, 2, "t6wp");
        do_rd(0, BASE + 1, 32'h0, 1'b0, 2, "t6rp");
        do_wr(0, BASE + 256, 32'h5, 4'hF, 1'b0, 2, "t6wok");
        do_rd(0, BASE + 256, 32'h5, 1'b0, 2, "t6rok");
`else
        do_wr(0, BASE + 1, 32'h5, 4'hF, 1'b0, 2, "t6w");
        do_rd(0, BASE + 1, 32'h5, 1'b0, 2, "t6r");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
